// File: rtl/shift_left_normalize.sv
// shift_left_normalize: iterative signed normalizer that strips redundant sign bits
module shift_left_normalize #(
    parameter int WIDTH = 8,
    parameter int SHIFT_VAL_WIDTH = $clog2(WIDTH)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out,
    output logic [SHIFT_VAL_WIDTH-1:0] shift,
    output logic                       zero
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic [SHIFT_VAL_WIDTH:0] LIM = (SHIFT_VAL_WIDTH+1)'(WIDTH-1);
    state_t state, state_nxt;
    logic [WIDTH-1:0] v, diff, mask;
    logic [SHIFT_VAL_WIDTH-1:0] c, k;
    logic [SHIFT_VAL_WIDTH:0] step, sum;
    logic z, take;
    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;
    assign out = v;
    assign shift = c;
    assign zero = z;
    // stage decision: the top step+1 bits match when the top step adjacent-bit XORs are all zero
    always_comb begin
        step = (SHIFT_VAL_WIDTH+1)'(1) << k;
        sum = {1'b0, c} + step;
        diff = v ^ (v << 1);
        mask = ~({WIDTH{1'b1}} >> step);
        take = step <= LIM && (diff & mask) == '0 && sum <= LIM;
    end
    // next-state logic
    always_comb begin
        state_nxt = state;
        state_nxt = state == IDLE ? (in_valid ? SHIFT : IDLE) :
                    state == SHIFT ? (k == '0 ? DONE : SHIFT) :
                    (out_ready ? IDLE : DONE);
    end
    // state register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else state <= state_nxt;
    end
    // working value, shift count, stage index and zero flag
    always_ff @(posedge clock) begin
        if (reset) begin
            v <= '0;
            c <= '0;
            k <= '0;
            z <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            v <= in;
            c <= '0;
            k <= SHIFT_VAL_WIDTH'(SHIFT_VAL_WIDTH-1);
            z <= in == '0;
        end else if (state == SHIFT) begin
            if (take) begin
                v <= v << step;
                c <= sum[SHIFT_VAL_WIDTH-1:0];
            end
            k <= k - 1'b1;
        end
    end
endmodule

// File: tb/tb_shift_left_normalize.sv
// tb_shift_left_normalize: table-driven and sequenced checks of the normalizer
module tb_shift_left_normalize;
    logic clock = 0, reset = 1, in_valid = 0, out_ready = 0;
    logic [7:0] in = 0;
    logic in_ready, out_valid, zero;
    logic [7:0] out;
    logic [2:0] shift;
    int checks = 0, failures = 0;
    typedef struct {logic [7:0] x; logic [7:0] eo; logic [2:0] es; logic ez;} vec_t;
    vec_t tab[12];

    shift_left_normalize #(.WIDTH(8)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in(in),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .shift(shift), .zero(zero)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic int rsb(input logic [7:0] x);
        int n = 0;
        for (int i = 6; i >= 0; i--) begin
            if (x[i] != x[7]) break;
            n++;
        end
        return n;
    endfunction

    // called at a negedge with the DUT idle; returns at a negedge with the DUT idle again
    task automatic xfer(input logic [7:0] x, input logic [7:0] eo, input logic [2:0] es,
                        input logic ez, input int hold);
        int n;
        chk("in_ready_idle", in_ready, 1);
        in = x;
        in_valid = 1;
        out_ready = hold == 0;
        n = 0;
        do begin
            @(negedge clock);
            in_valid = 0;
            in = ~x;
            n++;
        end while (!out_valid && n < 20);
        chk("latency_edges", n, 4);
        for (int i = 0; i <= hold; i++) begin
            chk("out", out, eo);
            chk("shift", shift, es);
            chk("zero", zero, ez);
            chk("in_ready_busy", in_ready, 0);
            chk("out_valid_held", out_valid, 1);
            if (i < hold) begin
                in_valid = 1;
                in = 8'h11;
                @(negedge clock);
                in_valid = 0;
            end
        end
        out_ready = 1;
        @(negedge clock);
        out_ready = 0;
        chk("out_valid_drop", out_valid, 0);
        chk("in_ready_back", in_ready, 1);
    endtask

    initial begin
        tab[0]  = '{8'h05, 8'h50, 3'd4, 1'b0};
        tab[1]  = '{8'hFD, 8'hA0, 3'd5, 1'b0};
        tab[2]  = '{8'h40, 8'h40, 3'd0, 1'b0};
        tab[3]  = '{8'h80, 8'h80, 3'd0, 1'b0};
        tab[4]  = '{8'h00, 8'h00, 3'd7, 1'b1};
        tab[5]  = '{8'hFF, 8'h80, 3'd7, 1'b0};
        tab[6]  = '{8'h7F, 8'h7F, 3'd0, 1'b0};
        tab[7]  = '{8'h01, 8'h40, 3'd6, 1'b0};
        tab[8]  = '{8'h20, 8'h40, 3'd1, 1'b0};
        tab[9]  = '{8'hC0, 8'h80, 3'd1, 1'b0};
        tab[10] = '{8'hE0, 8'h80, 3'd2, 1'b0};
        tab[11] = '{8'h03, 8'h60, 3'd5, 1'b0};
        repeat (2) @(negedge clock);
        reset = 0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", out, 0);
        chk("rst_shift", shift, 0);
        chk("rst_zero", zero, 0);
        foreach (tab[i]) xfer(tab[i].x, tab[i].eo, tab[i].es, tab[i].ez, 0);
        // backpressure with rejected input pulses, then no stray acceptance
        xfer(8'h03, 8'h60, 3'd5, 1'b0, 5);
        repeat (6) begin
            @(negedge clock);
            chk("no_stray_output", out_valid, 0);
        end
        // reset two cycles into a computation
        in = 8'h01;
        in_valid = 1;
        @(negedge clock);
        in_valid = 0;
        @(negedge clock);
        reset = 1;
        @(negedge clock);
        reset = 0;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out", out, 0);
        chk("midrst_shift", shift, 0);
        chk("midrst_zero", zero, 0);
        repeat (5) begin
            @(negedge clock);
            chk("midrst_no_output", out_valid, 0);
        end
        // reset together with in_valid must not accept
        reset = 1;
        in_valid = 1;
        in = 8'h05;
        @(negedge clock);
        reset = 0;
        in_valid = 0;
        chk("rst_valid_in_ready", in_ready, 1);
        chk("rst_valid_out", out, 0);
        xfer(8'h01, 8'h40, 3'd6, 1'b0, 0);
        // random values against the reference model
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] x;
            int r;
            x = 8'($urandom);
            r = rsb(x);
            xfer(x, x << r, 3'(r), x == 0, int'($urandom_range(0, 2)));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
